// File: rtl/time_entry.sv
// Keypad time-entry front end: collects M:SS digits, validates the entry and
// issues the load/start handshake to the countdown chain, then locks until zero or abort.
module time_entry (
  input  logic       clock,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_zero,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic       start,
  output logic       error,
  output logic       abort,
  output logic       locked,
  output logic [1:0] digit_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_LOAD   = 3'd2,
    S_ARM    = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t     state_q;
  logic [3:0] min_ones_q;
  logic [3:0] sec_tens_q;
  logic [3:0] sec_ones_q;
  logic [1:0] digit_count_q;
  logic       loadn_q;
  logic       start_q;
  logic       error_q;
  logic       abort_q;
  logic       locked_q;

  logic       key_digit_s;
  logic       key_clear_s;
  logic       key_start_s;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  assign key_digit_s = key_valid && is_digit(key_code);
  assign key_clear_s = key_valid && (key_code == 4'd10);
  assign key_start_s = key_valid && (key_code == 4'd11);

  // Entry/countdown FSM; every output is a register so the counters see clean levels.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q       <= S_IDLE;
      min_ones_q    <= 4'd0;
      sec_tens_q    <= 4'd0;
      sec_ones_q    <= 4'd0;
      digit_count_q <= 2'd0;
      loadn_q       <= 1'b1;
      start_q       <= 1'b0;
      error_q       <= 1'b0;
      abort_q       <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      loadn_q <= 1'b1;
      start_q <= 1'b0;
      error_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE, S_ENTRY: begin
          if (key_digit_s) begin
            if (digit_count_q != 2'd3) begin
              min_ones_q    <= sec_tens_q;
              sec_tens_q    <= sec_ones_q;
              sec_ones_q    <= key_code;
              digit_count_q <= digit_count_q + 2'd1;
              state_q       <= S_ENTRY;
            end else begin
              state_q <= state_q;
            end
          end else if (key_clear_s) begin
            min_ones_q    <= 4'd0;
            sec_tens_q    <= 4'd0;
            sec_ones_q    <= 4'd0;
            digit_count_q <= 2'd0;
            state_q       <= S_IDLE;
          end else if (key_start_s && (state_q == S_ENTRY)) begin
            if (sec_tens_q > 4'd5) begin
              error_q <= 1'b1;
            end else begin
              loadn_q <= 1'b0;
              state_q <= S_LOAD;
            end
          end else begin
            state_q <= state_q;
          end
        end
        S_LOAD: begin
          start_q  <= 1'b1;
          locked_q <= 1'b1;
          state_q  <= S_ARM;
        end
        S_ARM: begin
          state_q <= S_LOCKED;
        end
        S_LOCKED: begin
          // CLEAR takes priority over a simultaneous zero so the user sees the abort.
          if (key_clear_s || timer_zero) begin
            abort_q       <= key_clear_s;
            min_ones_q    <= 4'd0;
            sec_tens_q    <= 4'd0;
            sec_ones_q    <= 4'd0;
            digit_count_q <= 2'd0;
            locked_q      <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            state_q <= S_LOCKED;
          end
        end
        default: begin
          min_ones_q    <= 4'd0;
          sec_tens_q    <= 4'd0;
          sec_ones_q    <= 4'd0;
          digit_count_q <= 2'd0;
          locked_q      <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign min_ones    = min_ones_q;
  assign sec_tens    = sec_tens_q;
  assign sec_ones    = sec_ones_q;
  assign digit_count = digit_count_q;
  assign loadn       = loadn_q;
  assign start       = start_q;
  assign error       = error_q;
  assign abort       = abort_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_time_entry.sv
// Bench for time_entry: directed key sequences; pulse events are checked
// against a scoreboard queue by an independent monitor.
module tb_time_entry;

  logic       clock;
  logic       clearn;
  logic       key_valid;
  logic [3:0] key_code;
  logic       timer_zero;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       loadn;
  logic       start;
  logic       error;
  logic       abort;
  logic       locked;
  logic [1:0] digit_count;

  time_entry dut (
    .clock       (clock),
    .clearn      (clearn),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .timer_zero  (timer_zero),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .loadn       (loadn),
    .start       (start),
    .error       (error),
    .abort       (abort),
    .locked      (locked),
    .digit_count (digit_count)
  );

  localparam int EV_LOAD  = 0;
  localparam int EV_START = 1;
  localparam int EV_ERROR = 2;
  localparam int EV_ABORT = 3;

  typedef struct {
    int kind;
    int mo;
    int st;
    int so;
    int cnt;
    int lck;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input int kind, input int mo, input int st, input int so,
                      input int cnt, input int lck);
    exp_t e;
    e.kind = kind; e.mo = mo; e.st = st; e.so = so; e.cnt = cnt; e.lck = lck;
    sb.push_back(e);
  endtask

  task automatic key(input int code);
    key_valid = 1'b1;
    key_code  = 4'(code);
    @(negedge clock);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic chk_digits(input string name, input int mo, input int st, input int so,
                            input int cnt);
    chk({name, "_min"}, int'(min_ones), mo);
    chk({name, "_tens"}, int'(sec_tens), st);
    chk({name, "_ones"}, int'(sec_ones), so);
    chk({name, "_cnt"}, int'(digit_count), cnt);
  endtask

  task automatic chk_reset_vals(input string name);
    chk_digits(name, 0, 0, 0, 0);
    chk({name, "_loadn"}, int'(loadn), 1);
    chk({name, "_start"}, int'(start), 0);
    chk({name, "_error"}, int'(error), 0);
    chk({name, "_abort"}, int'(abort), 0);
    chk({name, "_locked"}, int'(locked), 0);
  endtask

  // Monitor: every pulse the DUT presents must match the oldest expected event.
  always @(negedge clock) begin
    if (clearn) begin
      for (int k = 0; k < 4; k++) begin
        logic act;
        case (k)
          EV_LOAD:  act = ~loadn;
          EV_START: act = start;
          EV_ERROR: act = error;
          default:  act = abort;
        endcase
        if (act) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d, expected none at %0t", k, $time);
          end else begin
            mon_e = sb.pop_front();
            chk("ev_kind", k, mon_e.kind);
            chk("ev_min", int'(min_ones), mon_e.mo);
            chk("ev_tens", int'(sec_tens), mon_e.st);
            chk("ev_ones", int'(sec_ones), mon_e.so);
            chk("ev_cnt", int'(digit_count), mon_e.cnt);
            chk("ev_locked", int'(locked), mon_e.lck);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clearn     = 1'b0;
    key_valid  = 1'b0;
    key_code   = 4'd0;
    timer_zero = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    clearn = 1'b1;
    @(negedge clock);

    // Entry 1:30 and load
    key(1);  chk("e1_cnt", int'(digit_count), 1);
    key(3);  chk("e2_cnt", int'(digit_count), 2);
    key(0);  chk_digits("entry130", 1, 3, 0, 3);
    push(EV_LOAD, 1, 3, 0, 3, 0);
    push(EV_START, 1, 3, 0, 3, 1);
    key(11);
    chk("load_loadn", int'(loadn), 0);
    @(negedge clock);
    chk("arm_start", int'(start), 1);
    chk("arm_locked", int'(locked), 1);
    @(negedge clock);
    chk("lk_locked", int'(locked), 1);
    chk("lk_start", int'(start), 0);
    chk("lk_loadn", int'(loadn), 1);
    key(5);
    chk_digits("lk_keyign", 1, 3, 0, 3);
    timer_zero = 1'b1;
    @(negedge clock);
    timer_zero = 1'b0;
    chk("end1_locked", int'(locked), 0);
    chk_digits("end1", 0, 0, 0, 0);

    // Invalid seconds 2:75
    key(2); key(7); key(5);
    push(EV_ERROR, 2, 7, 5, 3, 0);
    key(11);
    chk("err_pulse", int'(error), 1);
    @(negedge clock);
    chk("err_one", int'(error), 0);
    chk("err_loadn", int'(loadn), 1);
    chk("err_locked", int'(locked), 0);
    chk_digits("err_keep", 2, 7, 5, 3);
    key(10);

    // Overflow, clear, ignored keys
    key(4); key(5); key(6); key(9);
    chk_digits("ovf", 4, 5, 6, 3);
    key(10);
    chk_digits("clr", 0, 0, 0, 0);
    chk("clr_abort", int'(abort), 0);
    key(12);
    chk("k12_cnt", int'(digit_count), 0);
    key(11);
    @(negedge clock);
    chk("idle_start_loadn", int'(loadn), 1);
    chk("idle_start_locked", int'(locked), 0);

    // Countdown end: stale zero through LOAD/ARM is ignored
    key(0); key(0); key(5);
    chk_digits("e005", 0, 0, 5, 3);
    push(EV_LOAD, 0, 0, 5, 3, 0);
    push(EV_START, 0, 0, 5, 3, 1);
    timer_zero = 1'b1;
    key(11);
    @(negedge clock);
    timer_zero = 1'b0;
    @(negedge clock);
    chk("stale_locked", int'(locked), 1);
    chk_digits("stale", 0, 0, 5, 3);
    repeat (3) @(negedge clock);
    chk("run_locked", int'(locked), 1);
    timer_zero = 1'b1;
    @(negedge clock);
    timer_zero = 1'b0;
    chk("end2_locked", int'(locked), 0);
    chk_digits("end2", 0, 0, 0, 0);

    // Abort collision: CLEAR and zero in the same cycle
    key(1); key(0); key(0);
    push(EV_LOAD, 1, 0, 0, 3, 0);
    push(EV_START, 1, 0, 0, 3, 1);
    key(11);
    repeat (2) @(negedge clock);
    chk("ab_locked_pre", int'(locked), 1);
    push(EV_ABORT, 0, 0, 0, 0, 0);
    timer_zero = 1'b1;
    key(10);
    timer_zero = 1'b0;
    chk("ab_pulse", int'(abort), 1);
    chk("ab_locked", int'(locked), 0);
    @(negedge clock);
    chk("ab_one", int'(abort), 0);
    key(7);
    chk("ab_idle_entry", int'(digit_count), 1);
    key(10);

    // Reset during LOAD
    key(2); key(3); key(0);
    push(EV_LOAD, 2, 3, 0, 3, 0);
    key(11);
    chk("rl_loadn_low", int'(loadn), 0);
    #2;
    clearn = 1'b0;
    #1;
    chk_reset_vals("rst_load");
    @(negedge clock);
    clearn = 1'b1;
    repeat (3) @(negedge clock);
    chk("rl_start", int'(start), 0);
    chk("rl_locked", int'(locked), 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/time_entry.md
# time_entry

Keypad time-entry front end for the microwave countdown chain. It accepts decimal key presses into an M:SS digit register, validates the entry, and issues a one-cycle active-low load plus a start pulse that initialise the minute and seconds counters. It then stays locked until the chain reports zero or the user aborts. It drives the counters' data, load and enable-start inputs, and reads their terminal zero flag back.

## Interface
- No parameters; widths fixed (BCD digits, 4 bits each).
- clock  in  1  system clock; all state changes on rising edge.
- clearn  in  1  asynchronous active-low reset; forces reset state immediately.
- key_valid  in  1  one-cycle strobe; key_code is sampled when high.
- key_code  in  4  0–9 digit; 10 CLEAR; 11 START; 12–15 ignored.
- timer_zero  in  1  high when the counter chain has reached 0:00 (level).
- min_ones  out  4  BCD minutes digit to the load bus and display.
- sec_tens  out  4  BCD tens-of-seconds digit; legal range 0–5.
- sec_ones  out  4  BCD seconds digit.
- loadn  out  1  active-low load to the counters; low exactly one cycle.
- start  out  1  one-cycle pulse enabling the countdown.
- error  out  1  one-cycle pulse on a rejected START.
- abort  out  1  one-cycle pulse on a CLEAR during a locked countdown.
- locked  out  1  high while a countdown is in progress.
- digit_count  out  2  number of digits entered, 0–3.

## Operation
- States: IDLE, ENTRY, LOAD, ARM, LOCKED.
- Reset (clearn=0), asynchronous:
  - all digits 0, digit_count 0, state IDLE;
  - loadn=1; start, error, abort and locked all 0.
- Digit key (0–9) in IDLE or ENTRY, with digit_count<3:
  - shift left: min_ones←sec_tens, sec_tens←sec_ones, sec_ones←key;
  - digit_count+1; state→ENTRY.
- Digit key with digit_count=3: ignored, with no change and no error.
- CLEAR in IDLE or ENTRY: digits←0, digit_count←0, state→IDLE, no pulse.
- START in IDLE (digit_count=0): ignored.
- START in ENTRY:
  - if sec_tens>5: error=1 for one cycle, digits retained, stay ENTRY;
  - otherwise: →LOAD.
- Entry of 0:00 (e.g. keys 0,0,0) followed by START is legal and runs a zero-length countdown.
- LOAD: loadn=0 for this cycle only; →ARM.
- ARM: loadn=1, start=1 for this cycle; →LOCKED.
- LOCKED:
  - locked=1; digit and START keys ignored.
  - timer_zero=1 (sampled from the cycle after ARM onward): digits←0, digit_count←0, →IDLE.
  - CLEAR: abort=1 for one cycle, digits←0, digit_count←0, →IDLE.
  - CLEAR and timer_zero in the same cycle: CLEAR wins, so abort pulses.
- key_valid during LOAD or ARM is dropped.
- Keys 12–15 are ignored in every state.

## Timing
- Key sampled at edge N; digit outputs and digit_count are valid after edge N.
- START accepted at edge N:
  - loadn low during cycle N+1;
  - start high during cycle N+2;
  - locked high from cycle N+2.
- Digit outputs are stable from edge N until state returns to IDLE, so data is valid for the whole loadn-low cycle.
- error and abort assert the cycle after the triggering key and last exactly one cycle.
- timer_zero is ignored in LOAD and ARM, because the stale zero from before the load is still present.
- All outputs are registered.
- An asynchronous reset mid-LOAD or mid-LOCKED returns loadn to 1 and locked to 0 immediately.

## Test plan
- Entry and load:
  - Stimulus: reset, then keys 1,3,0, START.
  - Required: digits 1/3/0, digit_count 3; loadn=0 for one cycle carrying 1:30; start pulses next cycle; locked=1.
- Invalid seconds:
  - Stimulus: keys 2,7,5, START.
  - Required: error pulses for one cycle; no loadn pulse; state ENTRY, digits 2/7/5 kept.
- Overflow and clear:
  - Stimulus: keys 4,5,6,9.
  - Required: fourth key ignored, digits 4/5/6.
  - Then CLEAR: all digits 0, digit_count 0, no abort.
- Countdown end:
  - Stimulus: load 0:05, hold timer_zero=1 through LOAD/ARM, drop it, raise it again later.
  - Required: only the later assertion returns to IDLE with digits 0.
- Abort collision:
  - Stimulus: in LOCKED, CLEAR and timer_zero in the same cycle.
  - Required: abort=1 for one cycle; state IDLE.
- Reset mid-operation:
  - Stimulus: clearn low during the LOAD cycle.
  - Required: loadn goes 1 immediately; no start pulse; all outputs at reset values.
